// File: rtl/pmem_arbiter_if.sv
// Bus bundle between the IFU/LSU requesters, the arbiter and the PMEM model.
// slave is the arbiter's view; master is the environment (requesters + memory).
interface pmem_arbiter_if;
  // IFU fetch channel
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;
  // LSU load/store channel
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [7:0]  lsu_wmask;
  logic [31:0] lsu_wdata;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  // PMEM channel
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [7:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        bus_err;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wmask, lsu_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    output lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    output mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    output bus_err
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wmask, lsu_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rdata,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rdata,
    input  mem_req_valid, mem_addr, mem_wen, mem_wmask, mem_wdata,
    input  bus_err
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Single-outstanding PMEM arbiter for IFU and LSU. LSU wins contention
// unless the IFU has lost MAX_STARVE contended grants in a row. A response
// that never arrives is terminated after TIMEOUT cycles with a bus error.
module pmem_arbiter #(
  parameter int MAX_STARVE = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  pmem_arbiter_if.slave bus
);

  // +2 keeps the widths >= 1 and leaves headroom for the compare value
  localparam int SW = $clog2(MAX_STARVE + 2);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] to_q, to_d;
  logic [31:0]   addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [7:0]    wmask_q, wmask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;

  logic          gnt_ifu, gnt_lsu, starved;
  logic          rsp_fire;
  logic [31:0]   rsp_data;

  // State and latched payload registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_IFU;
      starve_q <= '0;
      to_q     <= '0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wmask_q  <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      to_q     <= to_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wmask_q  <= wmask_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
    end
  end

  // Grant decision, next state and response generation
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    to_d     = to_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wmask_d  = wmask_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    gnt_ifu  = 1'b0;
    gnt_lsu  = 1'b0;
    starved  = 1'b0;
    rsp_fire = 1'b0;
    rsp_data = '0;

    case (state_q)
      S_IDLE: begin
        // rst gating keeps the readies low while reset is held
        if (!rst) begin
          starved = (starve_q == SW'(MAX_STARVE));
          gnt_lsu = bus.lsu_req_valid && !(bus.ifu_req_valid && starved);
          gnt_ifu = bus.ifu_req_valid && !gnt_lsu;
        end
        if (gnt_lsu) begin
          addr_d  = bus.lsu_addr;
          wen_d   = bus.lsu_wen;
          wmask_d = bus.lsu_wmask;
          wdata_d = bus.lsu_wdata;
          owner_d = OWN_LSU;
          state_d = S_REQ;
          // LSU only beats a waiting IFU while not starved, so this saturates
          if (bus.ifu_req_valid && !starved) starve_d = starve_q + SW'(1);
        end else if (gnt_ifu) begin
          addr_d   = bus.ifu_addr;
          wen_d    = 1'b0;
          wmask_d  = 8'h0F;
          wdata_d  = '0;
          owner_d  = OWN_IFU;
          state_d  = S_REQ;
          starve_d = '0;
        end
      end
      S_REQ: begin
        if (bus.mem_req_ready) begin
          state_d = S_RSP;
          to_d    = '0;
        end
      end
      S_RSP: begin
        if (bus.mem_rsp_valid) begin
          rsp_fire = 1'b1;
          rsp_data = bus.mem_rdata;
          state_d  = S_IDLE;
        end else if (to_q == TW'(TIMEOUT)) begin
          rsp_fire = 1'b1;
          err_d    = 1'b1;
          state_d  = S_IDLE;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ifu_req_ready = gnt_ifu;
  assign bus.lsu_req_ready = gnt_lsu;

  // Responses go only to the recorded owner; stores return zero data
  assign bus.ifu_rsp_valid = rsp_fire && (owner_q == OWN_IFU);
  assign bus.ifu_rdata     = (rsp_fire && owner_q == OWN_IFU) ? rsp_data : '0;
  assign bus.lsu_rsp_valid = rsp_fire && (owner_q == OWN_LSU);
  assign bus.lsu_rdata     = (rsp_fire && owner_q == OWN_LSU && !wen_q) ? rsp_data : '0;

  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wen       = wen_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.bus_err       = err_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: inputs change on the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_pmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  pmem_arbiter_if bus();

  pmem_arbiter #(.MAX_STARVE(3), .TIMEOUT(255)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    bit [4:0] exp_lsu;
    int       quiet_bad;

    bus.ifu_req_valid = 1'b1;   // request during reset must not be granted
    bus.ifu_addr      = 32'h8000_0000;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_addr      = '0;
    bus.lsu_wen       = 1'b0;
    bus.lsu_wmask     = '0;
    bus.lsu_wdata     = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h1234_5678;

    // ---- reset state ----
    step(); #1;
    chk("rst_ifu_ready", bus.ifu_req_ready, 0);
    chk("rst_lsu_ready", bus.lsu_req_ready, 0);
    chk("rst_ifu_rsp",   bus.ifu_rsp_valid, 0);
    chk("rst_lsu_rsp",   bus.lsu_rsp_valid, 0);
    chk("rst_mem_valid", bus.mem_req_valid, 0);
    chk("rst_mem_addr",  bus.mem_addr, 0);
    chk("rst_bus_err",   bus.bus_err, 0);
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    step(); rst = 1'b0;

    // ---- 1: IFU only, minimum latency ----
    step(); bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0000; #1;
    chk("t1_c0_ifu_ready", bus.ifu_req_ready, 1);
    chk("t1_c0_lsu_ready", bus.lsu_req_ready, 0);
    chk("t1_c0_mem_valid", bus.mem_req_valid, 0);
    step(); bus.ifu_req_valid = 1'b0; #1;
    chk("t1_c1_mem_valid", bus.mem_req_valid, 1);
    chk("t1_c1_mem_addr",  bus.mem_addr, 32'h8000_0000);
    chk("t1_c1_mem_wen",   bus.mem_wen, 0);
    chk("t1_c1_mem_wmask", bus.mem_wmask, 8'h0F);
    step(); bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h0000_0413; #1;
    chk("t1_c2_ifu_rsp",   bus.ifu_rsp_valid, 1);
    chk("t1_c2_ifu_rdata", bus.ifu_rdata, 32'h0000_0413);
    chk("t1_c2_lsu_rsp",   bus.lsu_rsp_valid, 0);
    chk("t1_c2_mem_valid", bus.mem_req_valid, 0);

    // ---- 2: contention, LSU store wins, IFU next ----
    step();
    bus.mem_rsp_valid = 1'b0;
    bus.ifu_req_valid = 1'b1; bus.ifu_addr  = 32'h8000_0004;
    bus.lsu_req_valid = 1'b1; bus.lsu_addr  = 32'h8000_1000;
    bus.lsu_wen = 1'b1; bus.lsu_wdata = 32'hCAFE_BABE; bus.lsu_wmask = 8'h0F; #1;
    chk("t2_lsu_ready", bus.lsu_req_ready, 1);
    chk("t2_ifu_ready", bus.ifu_req_ready, 0);
    step(); bus.lsu_req_valid = 1'b0; #1;
    chk("t2_mem_wen",   bus.mem_wen, 1);
    chk("t2_mem_addr",  bus.mem_addr, 32'h8000_1000);
    chk("t2_mem_wdata", bus.mem_wdata, 32'hCAFE_BABE);
    chk("t2_mem_wmask", bus.mem_wmask, 8'h0F);
    step(); bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF; #1;
    chk("t2_lsu_rsp",   bus.lsu_rsp_valid, 1);
    chk("t2_lsu_rdata", bus.lsu_rdata, 0);
    chk("t2_ifu_rsp",   bus.ifu_rsp_valid, 0);
    step(); bus.mem_rsp_valid = 1'b0; #1;
    chk("t2_ifu_next", bus.ifu_req_ready, 1);
    step(); bus.ifu_req_valid = 1'b0; #1;
    chk("t2_ifu_addr",  bus.mem_addr, 32'h8000_0004);
    chk("t2_ifu_wmask", bus.mem_wmask, 8'h0F);
    step(); bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h0000_0013; #1;
    chk("t2_ifu_rsp", bus.ifu_rsp_valid, 1);

    // ---- 3: starvation LSU,LSU,LSU,IFU then LSU again ----
    exp_lsu = 5'b10111;   // bit i = LSU expected to win round i
    bus.lsu_wen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      bus.mem_rsp_valid = 1'b0;
      bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0100;
      bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_2000 + 32'(i * 4); #1;
      chk($sformatf("t3_r%0d_lsu_ready", i), bus.lsu_req_ready, 32'(exp_lsu[i]));
      chk($sformatf("t3_r%0d_ifu_ready", i), bus.ifu_req_ready, 32'(!exp_lsu[i]));
      step(); bus.lsu_req_valid = 1'b0; #1;
      chk($sformatf("t3_r%0d_addr", i), bus.mem_addr,
          exp_lsu[i] ? 32'h8000_2000 + 32'(i * 4) : 32'h8000_0100);
      step(); bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h0000_1000 + 32'(i); #1;
      chk($sformatf("t3_r%0d_lsu_rsp", i), bus.lsu_rsp_valid, 32'(exp_lsu[i]));
      chk($sformatf("t3_r%0d_ifu_rsp", i), bus.ifu_rsp_valid, 32'(!exp_lsu[i]));
      chk($sformatf("t3_r%0d_rdata", i), exp_lsu[i] ? bus.lsu_rdata : bus.ifu_rdata,
          32'h0000_1000 + 32'(i));
      chk($sformatf("t3_r%0d_no_ready", i), bus.ifu_req_ready, 0);
    end
    step(); bus.mem_rsp_valid = 1'b0; bus.ifu_req_valid = 1'b0;

    // ---- mem_rsp_valid in IDLE is ignored ----
    step(); bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h5555_5555; #1;
    chk("idle_rsp_ifu", bus.ifu_rsp_valid, 0);
    chk("idle_rsp_lsu", bus.lsu_rsp_valid, 0);

    // ---- 4: mem_req_ready low 5 cycles, payload stable ----
    step();
    bus.mem_rsp_valid = 1'b0; bus.mem_req_ready = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_3000; bus.lsu_wen = 1'b1;
    bus.lsu_wdata = 32'h1234_5678; bus.lsu_wmask = 8'h03; #1;
    chk("t4_accept", bus.lsu_req_ready, 1);
    step();
    bus.lsu_req_valid = 1'b1; bus.ifu_req_valid = 1'b1;
    bus.lsu_addr = 32'h0BAD_0BAD; bus.lsu_wdata = 32'h0;
    bus.mem_rsp_valid = 1'b1;   // also shows a response in REQ is ignored
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("t4_w%0d_valid", k), bus.mem_req_valid, 1);
      chk($sformatf("t4_w%0d_addr", k),  bus.mem_addr, 32'h8000_3000);
      chk($sformatf("t4_w%0d_wdata", k), bus.mem_wdata, 32'h1234_5678);
      chk($sformatf("t4_w%0d_wmask", k), bus.mem_wmask, 8'h03);
      chk($sformatf("t4_w%0d_ready", k), 32'(bus.ifu_req_ready | bus.lsu_req_ready), 0);
      chk($sformatf("t4_w%0d_rsp", k),   32'(bus.ifu_rsp_valid | bus.lsu_rsp_valid), 0);
      if (k < 4) step();
    end
    step();
    bus.mem_req_ready = 1'b1; bus.mem_rsp_valid = 1'b0;
    bus.lsu_req_valid = 1'b0; bus.ifu_req_valid = 1'b0; #1;
    chk("t4_hs_valid", bus.mem_req_valid, 1);
    step(); bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h7777_7777; #1;
    chk("t4_rsp",   bus.lsu_rsp_valid, 1);
    chk("t4_rdata", bus.lsu_rdata, 0);

    // ---- 5: timeout ----
    step();
    bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0200; #1;
    chk("t5_accept", bus.ifu_req_ready, 1);
    step(); bus.ifu_req_valid = 1'b0;
    quiet_bad = 0;
    for (int k = 0; k < 255; k++) begin
      step(); #1;
      if (bus.ifu_rsp_valid || bus.lsu_rsp_valid || bus.bus_err) quiet_bad++;
    end
    chk("t5_quiet", quiet_bad, 0);
    step(); #1;
    chk("t5_to_rsp",   bus.ifu_rsp_valid, 1);
    chk("t5_to_rdata", bus.ifu_rdata, 0);
    chk("t5_to_lsu",   bus.lsu_rsp_valid, 0);
    step(); #1;
    chk("t5_err_set", bus.bus_err, 1);
    chk("t5_rsp_gone", bus.ifu_rsp_valid, 0);
    // bus_err stays set across a normal transaction
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0204; #1;
    chk("t5_idle_again", bus.ifu_req_ready, 1);
    step(); bus.ifu_req_valid = 1'b0;
    step(); bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h0000_0093; #1;
    chk("t5_next_rdata", bus.ifu_rdata, 32'h0000_0093);
    chk("t5_err_sticky", bus.bus_err, 1);

    // ---- 6: reset while in RSP, late response ignored ----
    step();
    bus.mem_rsp_valid = 1'b0;
    bus.lsu_req_valid = 1'b1; bus.lsu_addr = 32'h8000_4000; bus.lsu_wen = 1'b0; #1;
    chk("t6_accept", bus.lsu_req_ready, 1);
    step(); bus.lsu_req_valid = 1'b0;
    step(); rst = 1'b1; #1;
    chk("t6_rst_rsp",   32'(bus.ifu_rsp_valid | bus.lsu_rsp_valid), 0);
    chk("t6_rst_mem",   bus.mem_req_valid, 0);
    chk("t6_rst_addr",  bus.mem_addr, 0);
    chk("t6_rst_err",   bus.bus_err, 0);
    step(); rst = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'hAAAA_AAAA; #1;
    chk("t6_late_lsu", bus.lsu_rsp_valid, 0);
    chk("t6_late_ifu", bus.ifu_rsp_valid, 0);
    step(); bus.mem_rsp_valid = 1'b0;
    bus.ifu_req_valid = 1'b1; bus.ifu_addr = 32'h8000_0300; #1;
    chk("t6_next_accept", bus.ifu_req_ready, 1);
    step(); bus.ifu_req_valid = 1'b0; #1;
    chk("t6_next_addr", bus.mem_addr, 32'h8000_0300);
    step(); bus.mem_rsp_valid = 1'b1; bus.mem_rdata = 32'h0000_0513; #1;
    chk("t6_next_rsp",   bus.ifu_rsp_valid, 1);
    chk("t6_next_rdata", bus.ifu_rdata, 32'h0000_0513);
    step(); bus.mem_rsp_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
